multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the RV32I-style core. It owns the program counter and instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. It feeds the latched instruction to `DECODER`, whose `aluOperation`/`immediateSelect` drive the datapath directly, and consumes the decoder's `stop` flag and the ALU compare result. It drives memory and register-file handshakes and write enables.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/opclass_decode.sv | 32 +++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I control slice.
// Contents:
//   - opcode constants for each instruction class
//   - ctrl_state_t, the controller state encoding
//   - wb_sel encodings
//   - NOP_INST, the reset value of the instruction register
//   - opclass_t, the one-hot opcode class vector
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } ctrl_state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Exactly one bit is set for a legal opcode; all zero means illegal.
    typedef struct packed {
        logic r;
        logic imm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  : inst[6:0] of the latched instruction
//   cls_o     : one-hot instruction class
//   illegal_o : high when the opcode matches no known class
module opclass_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opclass_t   cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_R:      cls_o.r      = 1'b1;
            OP_IMM:    cls_o.imm    = 1'b1;
            OP_LOAD:   cls_o.load   = 1'b1;
            OP_STORE:  cls_o.store  = 1'b1;
            OP_BRANCH: cls_o.branch = 1'b1;
            OP_JAL:    cls_o.jal    = 1'b1;
            OP_JALR:   cls_o.jalr   = 1'b1;
            OP_LUI:    cls_o.lui    = 1'b1;
            OP_AUIPC:  cls_o.auipc  = 1'b1;
            default:   cls_o        = '0;
        endcase
    end

    assign illegal_o = (cls_o == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller: owns PC and instruction register and
// steps each instruction through FETCH, DECODE, EXEC, MEM, WB (or HALT).
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   imem_req/addr/ready/rdata : instruction fetch handshake
//   inst                      : instruction register (to DECODER)
//   stop                      : halt request from DECODER (sampled in DECODE)
//   branch_taken              : ALU compare result (sampled in EXEC)
//   target_addr               : branch/jump target, low two bits ignored
//   dmem_req/we/ready         : data memory handshake
//   reg_we, wb_sel            : register-file write strobe and source select
//   pc, halted, illegal       : status
module multicycle_control
    import core_pkg::*;
#(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
)
(
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         inst,
    input  logic                stop,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] target_addr,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                illegal
);

    ctrl_state_t         state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         inst_q, inst_d;
    logic                illegal_q, illegal_d;
    logic                imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, halted_q;
    logic [1:0]          wb_sel_q, wb_sel_d;

    opclass_t            cls;
    logic                op_illegal;
    logic                alu_class;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] tgt;

    opclass_decode u_opclass (
        .opcode_i  (inst_q[6:0]),
        .cls_o     (cls),
        .illegal_o (op_illegal)
    );

    assign alu_class = cls.r | cls.imm | cls.lui | cls.auipc;
    assign pc_plus4  = pc_q + PC_WIDTH'(4);
    assign tgt       = target_addr & ~PC_WIDTH'(3);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                // The registered request gates ready, so a ready in the
                // bubble cycle right after reset is ignored.
                if (imem_req_q && imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (stop) begin
                    state_d = HALT;
                end else if (op_illegal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cls.branch) begin
                    pc_d    = branch_taken ? tgt : pc_plus4;
                    state_d = FETCH;
                end else if (cls.load || cls.store) begin
                    state_d = MEM;
                end else if (alu_class || cls.jal || cls.jalr) begin
                    state_d = WB;
                end else begin
                    // Unreachable once DECODE has filtered illegal opcodes.
                    state_d = HALT;
                end
            end
            MEM: begin
                if (dmem_req_q && dmem_ready) begin
                    if (cls.store) begin
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                pc_d    = (cls.jal || cls.jalr) ? tgt : pc_plus4;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        wb_sel_d = WB_ALU;
        if (state_d == WB) begin
            if (cls.load) begin
                wb_sel_d = WB_MEM;
            end else if (cls.jal || cls.jalr) begin
                wb_sel_d = WB_PC4;
            end
        end
    end

    // Outputs are registered from the next state so they are glitch-free
    // and hold steady for the whole time a state waits on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            wb_sel_q   <= WB_ALU;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            illegal_q  <= illegal_d;
            imem_req_q <= (state_d == FETCH);
            dmem_req_q <= (state_d == MEM);
            dmem_we_q  <= (state_d == MEM) && cls.store;
            reg_we_q   <= (state_d == WB);
            wb_sel_q   <= wb_sel_d;
            halted_q   <= (state_d == HALT);
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign inst      = inst_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_we    = reg_we_q;
    assign wb_sel    = wb_sel_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        stop;
    logic        branch_taken;
    logic [31:0] target_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    int          cyc, nwe, nd;
    logic [1:0]  wbs;
    logic        dwe, ast, tmo;

    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_JAL   = 32'h040000EF;
    localparam logic [31:0] I_BLT   = 32'h0420C063;
    localparam logic [31:0] I_LOAD  = 32'h0000A103;
    localparam logic [31:0] I_STORE = 32'h0020A023;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    multicycle_control #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .stop         (stop),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release and step one edge so the first fetch request is up.
    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        stop = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Act as zero-or-more-wait memories for one instruction starting in a
    // fetch-request cycle; stops when the next fetch starts or on halt.
    task automatic run_inst(input logic [31:0] instr, input int idly, input int ddly,
                            input logic [31:0] tgt, input logic tkn, input logic stp);
        int iw, dw;
        logic fetched;
        logic [31:0] a0;
        cyc = 0; nwe = 0; nd = 0; wbs = 2'b11; dwe = 1'b0; ast = 1'b1; tmo = 1'b1;
        iw = 0; dw = 0; fetched = 1'b0; a0 = imem_addr;
        target_addr = tgt; branch_taken = tkn; stop = stp; imem_rdata = instr;
        for (int k = 0; k < 60; k++) begin
            cyc++;
            if (imem_req && imem_addr !== a0) ast = 1'b0;
            if (reg_we) begin nwe++; wbs = wb_sel; end
            if (dmem_req) begin nd++; if (dmem_we) dwe = 1'b1; end
            imem_ready = imem_req && (iw >= idly);
            if (imem_req) begin
                if (iw >= idly) fetched = 1'b1;
                iw++;
            end
            dmem_ready = dmem_req && (dw >= ddly);
            if (dmem_req) dw++;
            tick();
            if (fetched && (imem_req || halted)) begin
                tmo = 1'b0;
                break;
            end
        end
        imem_ready = 1'b0; dmem_ready = 1'b0; stop = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; stop = 1'b0;
        branch_taken = 1'b0; target_addr = '0; imem_rdata = I_SUB;
        tick();
        tick();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (inst !== 32'h00000013) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst, 32'h13); end
        total++; if ({imem_req, dmem_req, dmem_we, reg_we} !== 4'b0000) begin bad++;
            $display("FAIL reset_reqs got=%b exp=0000", {imem_req, dmem_req, dmem_we, reg_we}); end
        total++; if ({halted, illegal, wb_sel} !== 4'b0000) begin bad++;
            $display("FAIL reset_status got=%b exp=0000", {halted, illegal, wb_sel}); end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_sub();
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL sub_timeout got=%b exp=0", tmo); end
        total++; if (cyc !== 4) begin bad++; $display("FAIL sub_cycles got=%0d exp=4", cyc); end
        total++; if (nwe !== 1) begin bad++; $display("FAIL sub_regwe got=%0d exp=1", nwe); end
        total++; if (wbs !== 2'd0) begin bad++; $display("FAIL sub_wbsel got=%0d exp=0", wbs); end
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL sub_pc got=%h exp=4", pc); end
        total++; if (inst !== I_SUB) begin bad++; $display("FAIL sub_inst got=%h exp=%h", inst, I_SUB); end
        total++; if (nd !== 0) begin bad++; $display("FAIL sub_dmem got=%0d exp=0", nd); end
    endtask

    task automatic test_jal();
        run_inst(I_JAL, 0, 0, 32'd64, 1'b0, 1'b0);
        total++; if (cyc !== 4 || tmo) begin bad++; $display("FAIL jal_cycles got=%0d exp=4", cyc); end
        total++; if (wbs !== 2'd2) begin bad++; $display("FAIL jal_wbsel got=%0d exp=2", wbs); end
        total++; if (nwe !== 1) begin bad++; $display("FAIL jal_regwe got=%0d exp=1", nwe); end
        total++; if (pc !== 32'd64) begin bad++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'd64); end
    endtask

    task automatic test_branch();
        do_reset();
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'd8) begin bad++; $display("FAIL blt_start_pc got=%h exp=8", pc); end
        run_inst(I_BLT, 0, 0, 32'd72, 1'b1, 1'b0);
        total++; if (pc !== 32'd72) begin bad++; $display("FAIL blt_taken_pc got=%h exp=%h", pc, 32'd72); end
        total++; if (cyc !== 3 || tmo) begin bad++; $display("FAIL blt_cycles got=%0d exp=3", cyc); end
        total++; if (nwe !== 0) begin bad++; $display("FAIL blt_regwe got=%0d exp=0", nwe); end
        do_reset();
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        run_inst(I_BLT, 0, 0, 32'd72, 1'b0, 1'b0);
        total++; if (pc !== 32'd12) begin bad++; $display("FAIL blt_nottaken_pc got=%h exp=%h", pc, 32'd12); end
        total++; if (nwe !== 0) begin bad++; $display("FAIL blt_nt_regwe got=%0d exp=0", nwe); end
    endtask

    task automatic test_store();
        run_inst(I_STORE, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (cyc !== 4 || tmo) begin bad++; $display("FAIL store_cycles got=%0d exp=4", cyc); end
        total++; if (dwe !== 1'b1) begin bad++; $display("FAIL store_we got=%b exp=1", dwe); end
        total++; if (nwe !== 0) begin bad++; $display("FAIL store_regwe got=%0d exp=0", nwe); end
        total++; if (pc !== 32'd16) begin bad++; $display("FAIL store_pc got=%h exp=%h", pc, 32'd16); end
    endtask

    task automatic test_wait_load();
        run_inst(I_LOAD, 2, 3, 32'h0, 1'b0, 1'b0);
        total++; if (cyc !== 10 || tmo) begin bad++; $display("FAIL load_cycles got=%0d exp=10", cyc); end
        total++; if (ast !== 1'b1) begin bad++; $display("FAIL load_addr_stable got=%b exp=1", ast); end
        total++; if (nd !== 4) begin bad++; $display("FAIL load_dmem_held got=%0d exp=4", nd); end
        total++; if (dwe !== 1'b0) begin bad++; $display("FAIL load_we got=%b exp=0", dwe); end
        total++; if (wbs !== 2'd1) begin bad++; $display("FAIL load_wbsel got=%0d exp=1", wbs); end
        total++; if (nwe !== 1) begin bad++; $display("FAIL load_regwe got=%0d exp=1", nwe); end
        total++; if (pc !== 32'd20) begin bad++; $display("FAIL load_pc got=%h exp=%h", pc, 32'd20); end
    endtask

    task automatic test_align_wrap();
        do_reset();
        run_inst(I_JAL, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL align_pc got=%h exp=fffffffc", pc); end
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    endtask

    task automatic test_halt();
        logic leak;
        logic [31:0] pc0;
        do_reset();
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b1);
        total++; if (halted !== 1'b1 || tmo) begin bad++; $display("FAIL stop_halted got=%b exp=1", halted); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL stop_illegal got=%b exp=0", illegal); end
        total++; if (nwe !== 0) begin bad++; $display("FAIL stop_regwe got=%0d exp=0", nwe); end
        pc0 = pc;
        leak = 1'b0;
        for (int k = 0; k < 5; k++) begin
            imem_ready = 1'b1; dmem_ready = 1'b1; imem_rdata = I_JAL; target_addr = 32'd64;
            tick();
            if (imem_req || dmem_req || reg_we || dmem_we || !halted) leak = 1'b1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%b exp=0", leak); end
        total++; if (pc !== pc0) begin bad++; $display("FAIL halt_pc got=%h exp=%h", pc, pc0); end
        total++; if (inst !== I_SUB) begin bad++; $display("FAIL halt_inst got=%h exp=%h", inst, I_SUB); end
        do_reset();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", halted); end
        run_inst(I_BAD, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ill_halted got=%b exp=1", halted); end
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b exp=1", illegal); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL ill_pc got=%h exp=0", pc); end
    endtask

    task automatic test_reset_mid_mem();
        int k;
        do_reset();
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        imem_rdata = I_LOAD;
        dmem_ready = 1'b0;
        k = 0;
        while (!dmem_req && k < 20) begin
            imem_ready = imem_req;
            tick();
            k++;
        end
        imem_ready = 1'b0;
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mid_mem_reach got=%b exp=1", dmem_req); end
        total++; if (pc !== 32'd4) begin bad++; $display("FAIL mid_mem_pc got=%h exp=4", pc); end
        rst = 1'b1;
        tick();
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_dmem got=%b exp=0", dmem_req); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
        total++; if (inst !== 32'h00000013) begin bad++; $display("FAIL rst_inst got=%h exp=13", inst); end
        total++; if ({imem_req, reg_we, halted} !== 3'b000) begin bad++;
            $display("FAIL rst_outs got=%b exp=000", {imem_req, reg_we, halted}); end
        rst = 1'b0;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++;
            $display("FAIL rst_refetch got=%b/%h exp=1/0", imem_req, imem_addr); end
        run_inst(I_SUB, 0, 0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'd4 || cyc !== 4) begin bad++;
            $display("FAIL rst_resume got=%h/%0d exp=4/4", pc, cyc); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_jal();
        test_branch();
        test_store();
        test_wait_load();
        test_align_wrap();
        test_halt();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
